// File: rtl/cp0_pkg.sv
// Shared constants for the coprocessor-0 interrupt controller: register numbers,
// SR/Cause bit positions and exception codes.
package cp0_pkg;

    localparam logic [4:0] REG_COUNT   = 5'd9;
    localparam logic [4:0] REG_COMPARE = 5'd11;
    localparam logic [4:0] REG_SR      = 5'd12;
    localparam logic [4:0] REG_CAUSE   = 5'd13;
    localparam logic [4:0] REG_EPC     = 5'd14;
    localparam logic [4:0] REG_PRID    = 5'd15;

    localparam int SR_IE         = 0;
    localparam int SR_EXL        = 1;
    localparam int SR_IM_LSB     = 8;
    localparam int CAUSE_EXC_LSB = 2;
    localparam int CAUSE_IP_LSB  = 8;
    localparam int CAUSE_TI      = 30;
    localparam int CAUSE_BD      = 31;

    typedef enum logic [4:0] {
        EXC_INT  = 5'd0,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_RI   = 5'd10,
        EXC_OV   = 5'd12
    } exc_code_t;

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer; ti latches when Count matches Compare and clears on a Compare write.
module cp0_timer (
    input  logic        clk,
    input  logic        reset,
    input  logic        we_count,
    input  logic        we_compare,
    input  logic [31:0] din,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        ti
);

    // Free-running counter, compare register and sticky match flag
    always_ff @(posedge clk) begin
        if (!reset) begin
            count   <= 32'd0;
            compare <= 32'd0;
            ti      <= 1'b0;
        end else begin
            count   <= we_count ? din : count + 32'd1;
            compare <= we_compare ? din : compare;
            // A Compare write acknowledges the timer even if a match lands the same edge
            if (we_compare) begin
                ti <= 1'b0;
            end else if (count == compare) begin
                ti <= 1'b1;
            end else begin
                ti <= ti;
            end
        end
    end

endmodule

// File: rtl/cp0_intc.sv
// Coprocessor 0 with level/edge hardware interrupts, internal timer interrupt and
// priority-encoded interrupt ID; raises req beside the M stage.
module cp0_intc
    import cp0_pkg::*;
#(
    parameter int               N_HW      = 6,
    parameter logic [N_HW-1:0]  EDGE_MASK = '0,
    parameter logic [31:0]      PRID      = 32'h0050_5249
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            we,
    input  logic [4:0]      addr,
    input  logic [31:0]     din,
    output logic [31:0]     dout,
    input  logic [31:0]     pc,
    input  logic            bd_in,
    input  logic [4:0]      exc_code_in,
    input  logic [N_HW-1:0] hw_int,
    input  logic            eret,
    output logic            req,
    output logic [31:0]     epc,
    output logic [2:0]      int_id
);

    localparam int NL = N_HW + 1;

    logic [31:0]     count_s;
    logic [31:0]     compare_s;
    logic            ti_s;
    logic [NL-1:0]   im_r;
    logic            exl_r;
    logic            ie_r;
    logic            bd_r;
    logic [4:0]      exc_code_r;
    logic [NL-1:0]   ip_r;
    logic [N_HW-1:0] hw_prev_r;
    logic [31:0]     epc_r;
    logic [NL-1:0]   pend_s;
    logic [NL-1:0]   ip_next_s;
    logic            int_req_s;
    logic            exc_req_s;
    logic            req_s;
    logic            wr_en_s;
    logic            cause_we_s;
    logic [31:0]     sr_s;
    logic [31:0]     cause_s;
    logic [2:0]      int_id_s;

    assign pend_s     = ip_r & im_r;
    assign int_req_s  = (|pend_s) & ie_r & ~exl_r;
    assign exc_req_s  = (exc_code_in != 5'd0) & ~exl_r;
    assign req_s      = reset & (int_req_s | exc_req_s);
    // An accepted exception swallows any mtc0 in the same cycle
    assign wr_en_s    = we & ~req_s;
    assign cause_we_s = wr_en_s & (addr == REG_CAUSE);

    assign req    = req_s;
    assign epc    = epc_r;
    assign int_id = int_id_s;

    cp0_timer u_timer (
        .clk        (clk),
        .reset      (reset),
        .we_count   (wr_en_s & (addr == REG_COUNT)),
        .we_compare (wr_en_s & (addr == REG_COMPARE)),
        .din        (din),
        .count      (count_s),
        .compare    (compare_s),
        .ti         (ti_s)
    );

    // Next pending vector: level lines follow the pin, edge lines are sticky until cleared by software
    always_comb begin
        ip_next_s = '0;
        for (int i = 0; i < N_HW; i++) begin
            if (EDGE_MASK[i]) begin
                ip_next_s[i] = (hw_int[i] & ~hw_prev_r[i])
                             | (ip_r[i] & ~(cause_we_s & ~din[CAUSE_IP_LSB + i]));
            end else begin
                ip_next_s[i] = hw_int[i];
            end
        end
        ip_next_s[N_HW] = ti_s;
    end

    // Lowest-numbered enabled pending line wins
    always_comb begin
        int_id_s = 3'd0;
        for (int i = NL - 1; i >= 0; i--) begin
            int_id_s = pend_s[i] ? 3'(i) : int_id_s;
        end
    end

    // Read-side assembly of SR/Cause and the mfc0 mux
    always_comb begin
        sr_s                     = 32'd0;
        sr_s[SR_IM_LSB +: NL]    = im_r;
        sr_s[SR_EXL]             = exl_r;
        sr_s[SR_IE]              = ie_r;
        cause_s                  = 32'd0;
        cause_s[CAUSE_BD]        = bd_r;
        cause_s[CAUSE_TI]        = ti_s;
        cause_s[CAUSE_IP_LSB +: NL] = ip_r;
        cause_s[CAUSE_EXC_LSB +: 5] = exc_code_r;
        case (addr)
            REG_COUNT:   dout = count_s;
            REG_COMPARE: dout = compare_s;
            REG_SR:      dout = sr_s;
            REG_CAUSE:   dout = cause_s;
            REG_EPC:     dout = epc_r;
            REG_PRID:    dout = PRID;
            default:     dout = 32'd0;
        endcase
    end

    // Architectural state: pending lines always advance; req beats mtc0 beats eret
    always_ff @(posedge clk) begin
        if (!reset) begin
            im_r       <= '0;
            exl_r      <= 1'b0;
            ie_r       <= 1'b0;
            bd_r       <= 1'b0;
            exc_code_r <= 5'd0;
            ip_r       <= '0;
            hw_prev_r  <= '0;
            epc_r      <= 32'd0;
        end else begin
            hw_prev_r <= hw_int;
            ip_r      <= ip_next_s;
            if (req_s) begin
                exc_code_r <= int_req_s ? EXC_INT : exc_code_in;
                bd_r       <= bd_in;
                epc_r      <= bd_in ? (pc - 32'd4) : pc;
                exl_r      <= 1'b1;
            end else if (we) begin
                case (addr)
                    REG_SR: begin
                        im_r  <= din[SR_IM_LSB +: NL];
                        exl_r <= din[SR_EXL];
                        ie_r  <= din[SR_IE];
                    end
                    REG_EPC: epc_r <= {din[31:2], 2'b00};
                    default: ;
                endcase
            end else if (eret) begin
                exl_r <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cp0_intc.sv
// Scoreboard bench for cp0_intc: stimulus queues hand-computed expectations per cycle,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_cp0_intc;

    logic        clk = 1'b0;
    logic        reset;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] din;
    logic [31:0] dout;
    logic [31:0] pc;
    logic        bd_in;
    logic [4:0]  exc_code_in;
    logic [5:0]  hw_int;
    logic        eret;
    logic        req;
    logic [31:0] epc;
    logic [2:0]  int_id;

    localparam int SEL_DOUT = 0;
    localparam int SEL_REQ  = 1;
    localparam int SEL_ID   = 2;
    localparam int SEL_EPC  = 3;

    typedef struct {
        int          cyc;
        int          sel;
        string       name;
        logic [31:0] val;
    } chk_t;

    chk_t        sb[$];
    chk_t        mon_e;
    logic [31:0] mon_act;
    int          cyc    = 0;
    int          checks = 0;
    int          errors = 0;

    cp0_intc #(.N_HW(6), .EDGE_MASK(6'b000001), .PRID(32'h0050_5249)) dut (
        .clk         (clk),
        .reset       (reset),
        .we          (we),
        .addr        (addr),
        .din         (din),
        .dout        (dout),
        .pc          (pc),
        .bd_in       (bd_in),
        .exc_code_in (exc_code_in),
        .hw_int      (hw_int),
        .eret        (eret),
        .req         (req),
        .epc         (epc),
        .int_id      (int_id)
    );

    always #5 clk = ~clk;

    // Monitor: compare every expectation due in the current cycle
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            mon_e = sb.pop_front();
            case (mon_e.sel)
                SEL_DOUT: mon_act = dout;
                SEL_REQ:  mon_act = {31'd0, req};
                SEL_ID:   mon_act = {29'd0, int_id};
                default:  mon_act = epc;
            endcase
            checks++;
            if (mon_act !== mon_e.val) begin
                errors++;
                $display("FAIL %s: got %h expected %h (cycle %0d)", mon_e.name, mon_act, mon_e.val, cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        we   = 1'b0;
        eret = 1'b0;
    endtask

    task automatic expect_chk(input string nm, input int sel, input logic [31:0] v);
        chk_t e;
        e.cyc  = cyc;
        e.sel  = sel;
        e.name = nm;
        e.val  = v;
        sb.push_back(e);
    endtask

    task automatic rd(input logic [4:0] a, input logic [31:0] v, input string nm);
        addr = a;
        expect_chk(nm, SEL_DOUT, v);
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        we   = 1'b1;
        addr = a;
        din  = d;
    endtask

    initial begin
        reset = 1'b0; we = 1'b0; addr = 5'd0; din = 32'd0; pc = 32'd0;
        bd_in = 1'b0; exc_code_in = 5'd10; hw_int = 6'd0; eret = 1'b0;

        // Reset values and req suppressed under reset
        tick();
        tick(); expect_chk("rst_req", SEL_REQ, 32'd0); rd(5'd12, 32'd0, "rst_sr");
        tick(); expect_chk("rst_req2", SEL_REQ, 32'd0); rd(5'd13, 32'd0, "rst_cause");
        tick(); rd(5'd14, 32'd0, "rst_epc");
        tick(); rd(5'd15, 32'h0050_5249, "rst_prid");
        tick(); reset = 1'b1; exc_code_in = 5'd0;

        // Level interrupt on line 2
        tick(); wr(5'd12, 32'h0000_0401);
        tick(); hw_int = 6'b000100; pc = 32'h0000_1000;
        tick(); expect_chk("lvl_req", SEL_REQ, 32'd1); expect_chk("lvl_id", SEL_ID, 32'd2);
        tick(); hw_int = 6'd0; rd(5'd14, 32'h0000_1000, "lvl_epc"); expect_chk("lvl_exl_blocks", SEL_REQ, 32'd0);
        tick(); rd(5'd12, 32'h0000_0403, "lvl_sr");
        tick(); rd(5'd13, 32'h4000_4000, "lvl_cause");
        tick(); eret = 1'b1;
        tick(); expect_chk("lvl_idle_req", SEL_REQ, 32'd0);

        // Sticky edge line 0
        tick(); wr(5'd12, 32'h0000_0103);
        tick(); hw_int = 6'b000001;
        tick(); hw_int = 6'd0; expect_chk("edge_exl_req", SEL_REQ, 32'd0);
        tick(); rd(5'd13, 32'h4000_4100, "edge_sticky"); expect_chk("edge_exl_req2", SEL_REQ, 32'd0);
        tick(); eret = 1'b1;
        tick(); pc = 32'h0000_2000; expect_chk("edge_req", SEL_REQ, 32'd1); expect_chk("edge_id", SEL_ID, 32'd0);
        tick(); wr(5'd13, 32'd0);
        tick(); eret = 1'b1;
        tick(); expect_chk("edge_cleared_req", SEL_REQ, 32'd0); rd(5'd13, 32'h4000_4000, "edge_cleared");

        // Timer interrupt on line 6
        tick(); wr(5'd9, 32'd15);
        tick(); wr(5'd11, 32'd20);
        tick(); wr(5'd12, 32'h0000_4001);
        tick(); expect_chk("tmr_req_early", SEL_REQ, 32'd0);
        tick();
        tick(); rd(5'd13, 32'd0, "tmr_ti_low");
        tick(); rd(5'd9, 32'd20, "tmr_count");
        tick(); rd(5'd13, 32'h4000_0000, "tmr_ti_set"); expect_chk("tmr_req_lag", SEL_REQ, 32'd0);
        tick(); expect_chk("tmr_req", SEL_REQ, 32'd1); expect_chk("tmr_id", SEL_ID, 32'd6);
        rd(5'd13, 32'h4000_4000, "tmr_ip");
        tick(); wr(5'd11, 32'd1000);
        tick(); eret = 1'b1;
        tick(); expect_chk("tmr_ack_req", SEL_REQ, 32'd0); rd(5'd13, 32'd0, "tmr_ack_cause");

        // Exception in a delay slot, then with a competing interrupt
        tick(); exc_code_in = 5'd12; bd_in = 1'b1; pc = 32'h0000_3010; expect_chk("exc_req", SEL_REQ, 32'd1);
        tick(); exc_code_in = 5'd0; bd_in = 1'b0; rd(5'd14, 32'h0000_300C, "exc_epc");
        tick(); rd(5'd13, 32'h8000_0030, "exc_cause");
        tick(); wr(5'd12, 32'h0000_0401); hw_int = 6'b000100;
        tick(); exc_code_in = 5'd12; bd_in = 1'b1; pc = 32'h0000_3010;
        expect_chk("mix_req", SEL_REQ, 32'd1); expect_chk("mix_id", SEL_ID, 32'd2);
        tick(); exc_code_in = 5'd0; bd_in = 1'b0; hw_int = 6'd0; rd(5'd13, 32'h8000_0400, "mix_cause");

        // req beats a same-cycle mtc0 and eret; Count wraps
        tick(); eret = 1'b1;
        tick(); exc_code_in = 5'd10; wr(5'd12, 32'd0); eret = 1'b1; pc = 32'h0000_4000;
        expect_chk("prio_req", SEL_REQ, 32'd1);
        tick(); exc_code_in = 5'd0; rd(5'd12, 32'h0000_0403, "prio_sr"); expect_chk("prio_epc", SEL_EPC, 32'h0000_4000);
        tick(); wr(5'd9, 32'hFFFF_FFFF);
        tick(); rd(5'd9, 32'hFFFF_FFFF, "wrap_pre");
        tick(); rd(5'd9, 32'd0, "wrap_post");

        // Reset in the middle of a handler
        tick(); reset = 1'b0; exc_code_in = 5'd5; expect_chk("midrst_req", SEL_REQ, 32'd0);
        tick(); reset = 1'b1; exc_code_in = 5'd0;
        rd(5'd12, 32'd0, "midrst_sr"); expect_chk("midrst_epc", SEL_EPC, 32'd0);
        expect_chk("midrst_req2", SEL_REQ, 32'd0);

        for (int i = 0; i < 4 && sb.size() > 0; i++) tick();
        tick();
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
